// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I field encoder: packs decoded fields into instruction
// words and writes them to instruction memory at sequential addresses.
module rv32i_instr_encoder #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_format,
  input  logic [2:0]       in_func3,
  input  logic             in_alt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  input  logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_e           state_q;
  logic             wr_en_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic             done_q;
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0] ecnt_q;

  logic        wr_fire;
  logic        in_fire;
  logic        last_wr;
  logic        legal;
  logic [31:0] enc;
  logic [6:0]  f7;

  assign wr_fire = wr_en_q && wr_ready;
  assign last_wr = wcnt_q == LAST;
  // Block refill when the final write drains so no beat is lost.
  assign in_ready = (state_q == RUN) &&
                    (!wr_en_q || (wr_ready && !last_wr));
  assign in_fire = in_valid && in_ready;
  assign f7 = in_imm[11:5];

  always_comb begin
    enc   = 32'b0;
    legal = 1'b1;
    unique case (in_format)
      3'd0: begin
        enc = {in_alt ? 7'b0100000 : 7'b0000000,
               in_rs2, in_rs1, in_func3, in_rd, 7'b0110011};
        legal = !in_alt || in_func3 == 3'b000 ||
                in_func3 == 3'b101;
      end
      3'd1: begin
        enc = {in_imm[11:0], in_rs1, in_func3, in_rd,
               7'b0010011};
        legal = !((in_func3 == 3'b001 && f7 != 7'b0) ||
                  (in_func3 == 3'b101 && f7 != 7'b0 &&
                   f7 != 7'b0100000));
      end
      3'd2: begin
        enc = {in_imm[11:0], in_rs1, in_func3, in_rd,
               7'b0000011};
        legal = in_func3 != 3'b011 && in_func3 != 3'b110 &&
                in_func3 != 3'b111;
      end
      3'd3: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, in_func3,
               in_imm[4:0], 7'b0100011};
        legal = in_func3 <= 3'b010;
      end
      3'd4: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
               in_func3, in_imm[4:1], in_imm[11], 7'b1100011};
        legal = in_func3 != 3'b010 && in_func3 != 3'b011 &&
                !in_imm[0];
      end
      3'd5: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11],
               in_imm[19:12], in_rd, 7'b1101111};
        legal = !in_imm[0];
      end
      3'd6: enc = {in_imm[31:12], in_rd, 7'b0110111};
      3'd7: enc = {in_imm[31:12], in_rd, 7'b0010111};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      addr_q  <= 32'b0;
      data_q  <= 32'b0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, FULL: begin
          if (start) begin
            state_q <= RUN;
            wr_en_q <= 1'b0;
            addr_q  <= base_addr & ~32'd3;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
            ecnt_q  <= '0;
          end
        end
        RUN: begin
          if (wr_fire) begin
            addr_q <= addr_q + 32'd4;
            wcnt_q <= wcnt_q + 1'b1;
            if (last_wr) begin
              state_q <= FULL;
              done_q  <= 1'b1;
            end
          end
          if (in_fire && legal) begin
            wr_en_q <= 1'b1;
            data_q  <= enc;
          end else if (wr_fire) begin
            wr_en_q <= 1'b0;
          end
          if (in_fire && !legal && ecnt_q != '1)
            ecnt_q <= ecnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = state_q == RUN;
  assign done       = done_q;
  assign word_count = wcnt_q;
  assign err_count  = ecnt_q;

endmodule
